const_terminal: RTL and testbench
=================================

CONST_TERMINAL -- requirements
Module: const_terminal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: bits per channel, legal 1..32.
REQ-002 The block SHALL have parameter CHANNELS, default 1: independent output channels, legal 1..8.
REQ-003 The block SHALL have parameter INIT_VALUE, default all ones (WIDTH bits): value every channel drives once active.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 0: cycles outputs stay at zero after reset release, legal 0..255.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ld_valid, input, 1 bit: load request.
REQ-008 The block SHALL have port ld_ready, output, 1 bit: load accepted when ld_valid and ld_ready are both high at a clock edge.
REQ-009 The block SHALL have port ld_chan, input, clog2(CHANNELS) bits (minimum 1): target channel.
REQ-010 The block SHALL have port ld_data, input, WIDTH bits: new channel value.
REQ-011 The block SHALL have port o, output, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 The block SHALL have port o_active, output, 1 bit: high once outputs carry their configured values.

Function
REQ-013 The state machine SHALL have exactly two states: HOLD and ACTIVE.
REQ-014 In HOLD, o SHALL be all zeros, o_active 0, ld_ready 0, and an 8-bit counter SHALL increment each cycle.
REQ-015 HOLD SHALL go to ACTIVE on the edge where the counter equals HOLD_CYCLES-1; with HOLD_CYCLES=0, the first edge after reset release SHALL go to ACTIVE.
REQ-016 On entry to ACTIVE, every channel SHALL be loaded with INIT_VALUE in the same edge, and o_active SHALL become 1.
REQ-017 ACTIVE SHALL be terminal until reset.
REQ-018 In ACTIVE, ld_ready SHALL be 1 every cycle; it SHALL have no combinational path from ld_valid.
REQ-019 On an accepted load, channel ld_chan SHALL take ld_data at that edge, and o SHALL reflect it in the following cycle (latency 1).
REQ-020 Other channels SHALL be unchanged by a load.
REQ-021 Back-to-back loads SHALL be accepted every cycle.
REQ-022 Repeated loads to the same channel SHALL result in the last value winning.
REQ-023 A load with ld_chan >= CHANNELS SHALL be accepted and discarded, leaving every channel unchanged.
REQ-024 ld_valid asserted in HOLD SHALL be ignored and SHALL NOT be queued.
REQ-025 ld_valid asserted on the HOLD-to-ACTIVE edge SHALL be ignored, because ld_ready is still 0.
REQ-026 o and o_active SHALL be driven directly from registers, with no combinational logic after the flops.
REQ-027 With CHANNELS=1, WIDTH=1, HOLD_CYCLES=0 and no loads, o SHALL be 1 from the first clock edge after reset release onward.

Reset
REQ-028 Assertion of reset_n low SHALL immediately, without a clock, force state HOLD, counter 0, o all zeros, o_active 0, and ld_ready 0.
REQ-029 Reset asserted mid-operation SHALL discard all loaded values; after release, the HOLD sequence SHALL restart from zero and channels SHALL return to INIT_VALUE.
REQ-030 Reset release SHALL be treated as synchronised externally; the block SHALL contain no internal reset synchroniser.

Structure
REQ-031 Package const_terminal_pkg SHALL hold the state enum (HOLD, ACTIVE), the 8-bit hold-counter width constant, and the WIDTH/CHANNELS legal-range constants.
REQ-032 Each channel register SHALL live in sub-module const_terminal_chan, instantiated CHANNELS times by generate.
REQ-033 const_terminal_chan SHALL take inputs clock, reset_n, init_en, ld_en and d, and SHALL drive output q (WIDTH bits).
REQ-034 In const_terminal_chan, init_en SHALL have priority over ld_en.
REQ-035 Elaboration SHALL fail on a parameter outside its legal range.

Verification
REQ-036 The bench SHALL cover: WIDTH=1, CHANNELS=1, HOLD_CYCLES=0, release reset -> o=1 and o_active=1 after the first edge; o=1 held for 100 cycles.
REQ-037 The bench SHALL cover: HOLD_CYCLES=5, WIDTH=8, CHANNELS=4, INIT_VALUE=8'hA5, with ld_valid=1 throughout HOLD -> o=0 and ld_ready=0 for exactly 5 edges, then o=32'hA5A5A5A5, and no load applied.
REQ-038 The bench SHALL cover: ACTIVE, loads (chan 2, 8'h3C) then (chan 0, 8'hFF) on consecutive cycles -> o=32'hA53CA5A5 one cycle after the first load, then 32'hA53CA5FF one cycle after the second.
REQ-039 The bench SHALL cover: CHANNELS=3, load with ld_chan=3, ld_data=8'h00 -> accepted (ld_ready=1), o unchanged.
REQ-040 The bench SHALL cover: after loads, assert reset_n low asynchronously between edges -> o=0 and o_active=0 immediately; after release, INIT_VALUE returns after HOLD_CYCLES edges.
REQ-041 The bench SHALL cover: same-channel loads 8'h11, 8'h22, 8'h33 back-to-back -> o channel 1 sequences 11, 22, 33 on successive cycles and holds 33.

Source files
------------

// File: rtl/const_terminal_pkg.sv
// Shared types and limits for the const_terminal block: FSM state encoding,
// hold-counter width and legal parameter ranges.
package const_terminal_pkg;

    typedef enum logic [0:0] {
        HOLD   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int HOLD_CNT_W      = 8;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 32;
    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 8;
    localparam int HOLD_CYCLES_MAX = 255;

endpackage

// File: rtl/const_terminal_chan.sv
// One channel register: cleared by reset, preset to INIT_VALUE on activation,
// otherwise overwritten by accepted loads.
module const_terminal_chan #(
    parameter int               WIDTH      = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             init_en,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Activation preset wins so a load racing the HOLD->ACTIVE edge cannot slip in.
    always_comb begin
        q_d = q_q;
        if (init_en) begin
            q_d = INIT_VALUE;
        end else if (ld_en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/const_terminal.sv
// Multi-channel constant source: outputs sit at zero for HOLD_CYCLES after reset,
// then every channel presents INIT_VALUE and can be rewritten through the load port.
module const_terminal
    import const_terminal_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               CHANNELS    = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE  = '1,
    parameter int               HOLD_CYCLES = 0,
    localparam int              CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [CHAN_W-1:0]         ld_chan,
    input  logic [WIDTH-1:0]          ld_data,
    output logic [CHANNELS*WIDTH-1:0] o,
    output logic                      o_active
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
            CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
            HOLD_CYCLES < 0 || HOLD_CYCLES > HOLD_CYCLES_MAX) begin : g_param_err
            $fatal(1, "const_terminal: parameter out of legal range");
        end
    endgenerate

    // HOLD_CYCLES of 0 and 1 both leave on the first edge after release.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
        (HOLD_CYCLES == 0) ? '0 : HOLD_CNT_W'(HOLD_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    active_q, active_d;
    logic                    init_en;
    logic                    ld_fire;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        init_en  = 1'b0;
        if (state_q == HOLD) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HOLD_LAST) begin
                state_d  = ACTIVE;
                active_d = 1'b1;
                init_en  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // Ready is a pure register output, so it never depends on ld_valid.
    assign ld_ready = active_q;
    assign o_active = active_q;
    assign ld_fire  = active_q & ld_valid;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic ld_en;
            // Out-of-range channel numbers match no instance and are dropped.
            assign ld_en = ld_fire && (ld_chan == CHAN_W'(gi));

            const_terminal_chan #(
                .WIDTH      (WIDTH),
                .INIT_VALUE (INIT_VALUE)
            ) u_chan (
                .clock   (clock),
                .reset_n (reset_n),
                .init_en (init_en),
                .ld_en   (ld_en),
                .d       (ld_data),
                .q       (o[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_const_terminal.sv
// Directed bench for const_terminal: three configurations share clock and reset
// and are stepped through hold, activation, loads and asynchronous reset.
module tb_const_terminal;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic        ld_valid1, ld_chan1, ld_data1, ld_ready1, o1, o_active1;

    logic        ld_valid4;
    logic [1:0]  ld_chan4;
    logic [7:0]  ld_data4;
    logic        ld_ready4;
    logic [31:0] o4;
    logic        o_active4;

    logic        ld_valid3;
    logic [1:0]  ld_chan3;
    logic [7:0]  ld_data3;
    logic        ld_ready3;
    logic [23:0] o3;
    logic        o_active3;

    int checks = 0;
    int errors = 0;

    const_terminal #(
        .WIDTH(1), .CHANNELS(1), .HOLD_CYCLES(0)
    ) u1 (
        .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid1), .ld_ready(ld_ready1),
        .ld_chan(ld_chan1), .ld_data(ld_data1), .o(o1), .o_active(o_active1)
    );

    const_terminal #(
        .WIDTH(8), .CHANNELS(4), .INIT_VALUE(8'hA5), .HOLD_CYCLES(5)
    ) u4 (
        .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid4), .ld_ready(ld_ready4),
        .ld_chan(ld_chan4), .ld_data(ld_data4), .o(o4), .o_active(o_active4)
    );

    const_terminal #(
        .WIDTH(8), .CHANNELS(3), .INIT_VALUE(8'hA5), .HOLD_CYCLES(0)
    ) u3 (
        .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid3), .ld_ready(ld_ready3),
        .ld_chan(ld_chan3), .ld_data(ld_data3), .o(o3), .o_active(o_active3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        ld_valid1 = 1'b0; ld_chan1 = 1'b0; ld_data1 = 1'b0;
        ld_valid3 = 1'b0; ld_chan3 = 2'd0; ld_data3 = 8'h00;
        // Load request held throughout HOLD must never take effect.
        ld_valid4 = 1'b1; ld_chan4 = 2'd1; ld_data4 = 8'h77;

        tick();
        tick();
        chk("rst_o1",       32'(o1),        32'h0);
        chk("rst_active1",  32'(o_active1), 32'h0);
        chk("rst_o4",       o4,             32'h0);
        chk("rst_ready4",   32'(ld_ready4), 32'h0);
        chk("rst_active4",  32'(o_active4), 32'h0);
        chk("rst_o3",       32'(o3),        32'h0);

        @(negedge clock);
        reset_n = 1'b1;

        tick();
        chk("first_edge_o1",      32'(o1),        32'h1);
        chk("first_edge_active1", 32'(o_active1), 32'h1);
        chk("first_edge_o3",      32'(o3),        32'h00A5A5A5);
        chk("hold_o4_e1",         o4,             32'h0);
        chk("hold_ready4_e1",     32'(ld_ready4), 32'h0);
        for (int e = 2; e <= 4; e++) begin
            tick();
            chk($sformatf("hold_o4_e%0d", e),     o4,             32'h0);
            chk($sformatf("hold_ready4_e%0d", e), 32'(ld_ready4), 32'h0);
            chk($sformatf("hold_act4_e%0d", e),   32'(o_active4), 32'h0);
        end
        tick();
        chk("activate_o4",      o4,             32'hA5A5A5A5);
        chk("activate_active4", 32'(o_active4), 32'h1);
        chk("activate_ready4",  32'(ld_ready4), 32'h1);
        ld_valid4 = 1'b0;
        tick();
        chk("no_queued_load",   o4,             32'hA5A5A5A5);

        ld_valid4 = 1'b1; ld_chan4 = 2'd2; ld_data4 = 8'h3C;
        tick();
        chk("load_c2",          o4,             32'hA53CA5A5);
        ld_chan4 = 2'd0; ld_data4 = 8'hFF;
        tick();
        chk("load_c0",          o4,             32'hA53CA5FF);

        ld_chan4 = 2'd1; ld_data4 = 8'h11;
        tick();
        chk("same_chan_11",     o4,             32'hA53C11FF);
        ld_data4 = 8'h22;
        tick();
        chk("same_chan_22",     o4,             32'hA53C22FF);
        ld_data4 = 8'h33;
        tick();
        chk("same_chan_33",     o4,             32'hA53C33FF);
        ld_valid4 = 1'b0;
        tick();
        chk("same_chan_hold",   o4,             32'hA53C33FF);

        ld_valid3 = 1'b1; ld_chan3 = 2'd3; ld_data3 = 8'h00;
        chk("oob_ready3",       32'(ld_ready3), 32'h1);
        tick();
        chk("oob_discard",      32'(o3),        32'h00A5A5A5);
        ld_chan3 = 2'd2; ld_data3 = 8'h5A;
        tick();
        chk("c3_load_c2",       32'(o3),        32'h005AA5A5);
        ld_valid3 = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("hold_one_%0d", i), 32'(o1), 32'h1);
        end

        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_o4",      o4,             32'h0);
        chk("async_active4", 32'(o_active4), 32'h0);
        chk("async_ready4",  32'(ld_ready4), 32'h0);
        chk("async_o1",      32'(o1),        32'h0);
        chk("async_o3",      32'(o3),        32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("rerun_o1",      32'(o1),        32'h1);
        chk("rerun_o3",      32'(o3),        32'h00A5A5A5);
        chk("rerun_o4_e1",   o4,             32'h0);
        for (int e = 2; e <= 4; e++) begin
            tick();
            chk($sformatf("rerun_o4_e%0d", e), o4, 32'h0);
        end
        tick();
        chk("rerun_init_o4", o4,             32'hA5A5A5A5);
        chk("rerun_active4", 32'(o_active4), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
